tick_scheduler: RTL

- Programmable rate controller for the system tick datapath.
- Owns two divider channels, FAST (display/scan rate) and SLOW (sequencing rate), running off the board clock.
- Emits single-cycle clock-enable strobes plus 50% square phases for downstream logic.
- Software/FSM can change either channel's divisor at run time through a valid/ready config port; a new divisor is applied only at that channel's period boundary, so no runt or stretched period is ever produced.

---
 rtl/tick_pkg.sv | 25 ++
 rtl/tick_scheduler_if.sv | 28 ++
 rtl/tick_channel.sv | 64 ++++++
 rtl/tick_scheduler.sv | 117 +++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_pkg
// Description : Shared widths, reset divisors, config FSM states and channel
//               select codes for the tick scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_pkg;

    localparam int unsigned CNT_W = 26;

    localparam logic [CNT_W-1:0] FAST_DIV_DEF = 26'd41667;
    localparam logic [CNT_W-1:0] SLOW_DIV_DEF = 26'd3333333;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } cfg_state_e;

    localparam logic SEL_FAST = 1'b0;
    localparam logic SEL_SLOW = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tick_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler_if
// Description : Valid/ready divisor configuration port of the tick scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_scheduler_if;
    import tick_pkg::*;

    logic             cfg_valid;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_sel, cfg_div,
        input  cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_div,
        output cfg_ready, cfg_done, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ============================================================================
// Module      : tick_channel
// Description : One divider channel: period counter, divisor register,
//               registered tick strobe and 50% square phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_channel
    import tick_pkg::*;
#(
    parameter logic [CNT_W-1:0] DIV_RST = FAST_DIV_DEF
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic             i_run,
    input  wire logic             i_load_en,
    input  wire logic [CNT_W-1:0] i_load_div,
    output logic                  o_tick,
    output logic                  o_sq,
    output logic                  o_at_term
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    // div_q is never below 2, so div_q-1 cannot wrap
    assign o_at_term = (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = i_run & o_at_term;
        if (i_run) begin
            cnt_d = o_at_term ? '0 : cnt_q + CNT_W'(1);
        end
        // A load lands on the wrap edge (or while frozen), restarting the period
        if (i_load_en) begin
            div_d = i_load_div;
            cnt_d = '0;
        end
        sq_d = (cnt_d < (div_d >> 1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_RST;
            tick_q <= 1'b0;
            sq_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign o_tick = tick_q;
    assign o_sq   = sq_q;

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Two-channel programmable tick generator with boundary-aligned
//               run-time divisor updates through a valid/ready config port.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_pkg::*;
#(
    parameter logic [CNT_W-1:0] FAST_DIV_RST = FAST_DIV_DEF,
    parameter logic [CNT_W-1:0] SLOW_DIV_RST = SLOW_DIV_DEF
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    input  wire logic        run,
    tick_scheduler_if.slave  cfg,
    output logic             tick_fast,
    output logic             tick_slow,
    output logic             sq_fast,
    output logic             sq_slow
);

    cfg_state_e       state_q;
    logic             stage_sel_q;
    logic [CNT_W-1:0] stage_div_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;

    logic             at_term_fast;
    logic             at_term_slow;
    logic             sel_term;
    logic             apply;
    logic             load_fast;
    logic             load_slow;

    assign sel_term  = (stage_sel_q == SEL_SLOW) ? at_term_slow : at_term_fast;
    // Frozen counters have no boundary to wait for, so apply immediately
    assign apply     = (state_q == PEND) && (!run || sel_term);
    assign load_fast = apply && (stage_sel_q == SEL_FAST);
    assign load_slow = apply && (stage_sel_q == SEL_SLOW);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stage_sel_q <= SEL_FAST;
            stage_div_q <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg.cfg_valid) begin
                        if (cfg.cfg_div < CNT_W'(2)) begin
                            err_q <= 1'b1;
                        end else begin
                            stage_sel_q <= cfg.cfg_sel;
                            stage_div_q <= cfg.cfg_div;
                            state_q     <= PEND;
                            ready_q     <= 1'b0;
                        end
                    end
                end
                PEND: begin
                    if (apply) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_done  = done_q;
    assign cfg.cfg_err   = err_q;

    tick_channel #(
        .DIV_RST    (FAST_DIV_RST)
    ) u_fast (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_run      (run),
        .i_load_en  (load_fast),
        .i_load_div (stage_div_q),
        .o_tick     (tick_fast),
        .o_sq       (sq_fast),
        .o_at_term  (at_term_fast)
    );

    tick_channel #(
        .DIV_RST    (SLOW_DIV_RST)
    ) u_slow (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_run      (run),
        .i_load_en  (load_slow),
        .i_load_div (stage_div_q),
        .o_tick     (tick_slow),
        .o_sq       (sq_slow),
        .o_at_term  (at_term_slow)
    );

endmodule
`default_nettype wire
